// File: rtl/autocat_epoch_sched.sv
// autocat_epoch_sched: time-multiplexes one autocat way-partition monitor
// across NUM_DSID tenants. Each epoch resets the monitor, forwards only the
// profiled DSID's LLC traffic, lets the sorter settle, then commits the
// suggested waymask through a valid/ready handshake.
// Optional build macro: AUTOCAT_SCHED_SKIP_SAME_EN -- keeps a per-DSID shadow
// of the last committed waymask and skips commits that would not change it.
module autocat_epoch_sched #(
  parameter int NUM_DSID            = 4,
  parameter int DSID_WIDTH          = 2,
  parameter int CACHE_ASSOCIATIVITY = 16,
  parameter int EPOCH_WIDTH         = 32,
  parameter int SETTLE_CYCLES       = 8
) (
  input  logic                           clk_in,
  input  logic                           reset_in,
  input  logic                           enable_in,
  input  logic [EPOCH_WIDTH-1:0]         epoch_len_in,
  input  logic                           access_valid_in,
  input  logic [DSID_WIDTH-1:0]          access_dsid_in,
  input  logic [CACHE_ASSOCIATIVITY-1:0] hit_vec_in,
  output logic                           monitor_reset_out,
  output logic                           monitor_access_valid_out,
  output logic [CACHE_ASSOCIATIVITY-1:0] monitor_hit_vec_out,
  input  logic [CACHE_ASSOCIATIVITY-1:0] suggested_waymask_in,
  output logic                           cfg_valid_out,
  output logic [DSID_WIDTH-1:0]          cfg_dsid_out,
  output logic [CACHE_ASSOCIATIVITY-1:0] cfg_waymask_out,
  input  logic                           cfg_ready_in,
  output logic [DSID_WIDTH-1:0]          cur_dsid_out,
  output logic                           busy_out
);

  localparam int CA = CACHE_ASSOCIATIVITY;
  localparam logic [EPOCH_WIDTH-1:0] EPOCH_ONE   = EPOCH_WIDTH'(1);
  localparam logic [EPOCH_WIDTH-1:0] SETTLE_LAST = EPOCH_WIDTH'(SETTLE_CYCLES);
  localparam logic [CA-1:0]          WAY0_ONLY   = CA'(1);
  localparam logic [DSID_WIDTH-1:0]  DSID_ONE    = DSID_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MONITOR = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_COMMIT  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [DSID_WIDTH-1:0]   cur_dsid_q, cur_dsid_d;
  logic [EPOCH_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    mon_rst_q, mon_rst_d;
  logic                    mon_valid_q;
  logic [CA-1:0]           mon_hit_q;
  logic [DSID_WIDTH-1:0]   cfg_dsid_q, cfg_dsid_d;
  logic [CA-1:0]           cfg_mask_q, cfg_mask_d;

  logic [EPOCH_WIDTH-1:0]  epoch_last;
  logic [CA-1:0]           sugg_fixed;
  logic                    handshake;
  logic                    pass_access;
  logic                    skip_same;

  // Last monitoring cycle of the epoch; a zero length behaves as one cycle.
  assign epoch_last  = (epoch_len_in == '0) ? '0 : (epoch_len_in - EPOCH_ONE);
  // An empty suggestion would starve the tenant, so fall back to way 0.
  assign sugg_fixed  = (suggested_waymask_in == '0) ? WAY0_ONLY : suggested_waymask_in;
  assign handshake   = (state_q == ST_COMMIT) && cfg_ready_in;
  assign pass_access = access_valid_in && (access_dsid_in == cur_dsid_q) &&
                       (state_q == ST_MONITOR);

`ifdef AUTOCAT_SCHED_SKIP_SAME_EN
  logic [CA-1:0] shadow_q [NUM_DSID];

  assign skip_same = (sugg_fixed == shadow_q[cur_dsid_q]);

  // Shadow of the waymask last accepted by the config block, per DSID.
  always_ff @(posedge clk_in) begin
    for (int i = 0; i < NUM_DSID; i++) begin
      if (reset_in) begin
        shadow_q[i] <= '1;
      end else if (handshake && (cfg_dsid_q == DSID_WIDTH'(i))) begin
        shadow_q[i] <= cfg_mask_q;
      end
    end
  end
`else
  assign skip_same = 1'b0;
`endif

  // Scheduler state register and commit payload.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      cur_dsid_q <= '0;
      cnt_q      <= '0;
      mon_rst_q  <= 1'b1;
      cfg_dsid_q <= '0;
      cfg_mask_q <= '1;
    end else begin
      state_q    <= state_d;
      cur_dsid_q <= cur_dsid_d;
      cnt_q      <= cnt_d;
      mon_rst_q  <= mon_rst_d;
      cfg_dsid_q <= cfg_dsid_d;
      cfg_mask_q <= cfg_mask_d;
    end
  end

  // Next-state logic: epoch counting, settle wait, sampling and handshake.
  always_comb begin
    state_d    = state_q;
    cur_dsid_d = cur_dsid_q;
    cnt_d      = cnt_q;
    mon_rst_d  = 1'b0;
    cfg_dsid_d = cfg_dsid_q;
    cfg_mask_d = cfg_mask_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_in) begin
          state_d   = ST_MONITOR;
          mon_rst_d = 1'b1;
          cnt_d     = '0;
        end
      end
      ST_MONITOR: begin
        // Live compare: a shortened epoch length past the counter only ends
        // the epoch once the counter wraps round to it again.
        if (cnt_q == epoch_last) begin
          state_d = ST_SETTLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + EPOCH_ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d = '0;
          if (skip_same) begin
            // Nothing would change in the partition config: move on.
            cur_dsid_d = cur_dsid_q + DSID_ONE;
            if (enable_in) begin
              state_d   = ST_MONITOR;
              mon_rst_d = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cfg_mask_d = sugg_fixed;
            cfg_dsid_d = cur_dsid_q;
            state_d    = ST_COMMIT;
          end
        end else begin
          cnt_d = cnt_q + EPOCH_ONE;
        end
      end
      ST_COMMIT: begin
        if (cfg_ready_in) begin
          cur_dsid_d = cur_dsid_q + DSID_ONE;
          cnt_d      = '0;
          if (enable_in) begin
            state_d   = ST_MONITOR;
            mon_rst_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Access filter: only the profiled DSID's lookups reach the monitor.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      mon_valid_q <= 1'b0;
      mon_hit_q   <= '0;
    end else begin
      mon_valid_q <= pass_access;
      mon_hit_q   <= pass_access ? hit_vec_in : '0;
    end
  end

  assign monitor_reset_out        = mon_rst_q;
  assign monitor_access_valid_out = mon_valid_q;
  assign monitor_hit_vec_out      = mon_hit_q;
  assign cfg_valid_out            = (state_q == ST_COMMIT);
  assign cfg_dsid_out             = cfg_dsid_q;
  assign cfg_waymask_out          = cfg_mask_q;
  assign cur_dsid_out             = cur_dsid_q;
  assign busy_out                 = (state_q != ST_IDLE);

endmodule

// File: tb/tb_autocat_epoch_sched.sv
// Directed bench for autocat_epoch_sched (default parameters).
module tb_autocat_epoch_sched;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        enable_in;
  logic [31:0] epoch_len_in;
  logic        access_valid_in;
  logic [1:0]  access_dsid_in;
  logic [15:0] hit_vec_in;
  logic        monitor_reset_out;
  logic        monitor_access_valid_out;
  logic [15:0] monitor_hit_vec_out;
  logic [15:0] suggested_waymask_in;
  logic        cfg_valid_out;
  logic [1:0]  cfg_dsid_out;
  logic [15:0] cfg_waymask_out;
  logic        cfg_ready_in;
  logic [1:0]  cur_dsid_out;
  logic        busy_out;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic [1:0] hs_log [$];

  autocat_epoch_sched dut (
    .clk_in                   (clk_in),
    .reset_in                 (reset_in),
    .enable_in                (enable_in),
    .epoch_len_in             (epoch_len_in),
    .access_valid_in          (access_valid_in),
    .access_dsid_in           (access_dsid_in),
    .hit_vec_in               (hit_vec_in),
    .monitor_reset_out        (monitor_reset_out),
    .monitor_access_valid_out (monitor_access_valid_out),
    .monitor_hit_vec_out      (monitor_hit_vec_out),
    .suggested_waymask_in     (suggested_waymask_in),
    .cfg_valid_out            (cfg_valid_out),
    .cfg_dsid_out             (cfg_dsid_out),
    .cfg_waymask_out          (cfg_waymask_out),
    .cfg_ready_in             (cfg_ready_in),
    .cur_dsid_out             (cur_dsid_out),
    .busy_out                 (busy_out)
  );

  always #5 clk_in = ~clk_in;

  // One line per completed commit handshake.
  always @(posedge clk_in) begin
    if (!reset_in && cfg_valid_out && cfg_ready_in) begin
      hs_log.push_back(cfg_dsid_out);
      $display("commit dsid=%0d waymask=%h t=%0t", cfg_dsid_out, cfg_waymask_out, $time);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Ticks until cfg_valid_out rises; returns the number of ticks taken.
  task automatic wait_valid(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (!cfg_valid_out && cycles < limit) begin
      tick();
      cycles++;
    end
    check_val(tag, {31'd0, cfg_valid_out}, 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_in = 1'b1; enable_in = 1'b0; epoch_len_in = 32'd4;
    access_valid_in = 1'b0; access_dsid_in = 2'd0; hit_vec_in = 16'h0;
    suggested_waymask_in = 16'h00FF; cfg_ready_in = 1'b1;
    repeat (3) tick();

    // Reset state
    check_val("rst_mrst",  monitor_reset_out, 1);
    check_val("rst_valid", cfg_valid_out, 0);
    check_val("rst_dsid",  cfg_dsid_out, 0);
    check_val("rst_mask",  cfg_waymask_out, 16'hFFFF);
    check_val("rst_busy",  busy_out, 0);
    check_val("rst_cur",   cur_dsid_out, 0);
    check_val("rst_mval",  monitor_access_valid_out, 0);
    check_val("rst_mhv",   monitor_hit_vec_out, 0);

    // First epoch: DSID 0, 4-cycle epoch, settle then commit 00FF
    reset_in = 1'b0; enable_in = 1'b1;
    tick();
    check_val("e1_pulse", monitor_reset_out, 1);
    check_val("e1_busy",  busy_out, 1);
    tick();
    check_val("e1_pulse_end", monitor_reset_out, 0);
    wait_valid("e1_to", 40, cyc);
    check_val("e1_lat",  cyc, 12);
    check_val("e1_dsid", cfg_dsid_out, 0);
    check_val("e1_mask", cfg_waymask_out, 16'h00FF);
    tick();
    check_val("e1_drop",  cfg_valid_out, 0);
    check_val("e1_cur",   cur_dsid_out, 1);
    check_val("e2_pulse", monitor_reset_out, 1);

    // Filter while profiling DSID 1
    access_valid_in = 1'b1; hit_vec_in = 16'h0004;
    access_dsid_in = 2'd0; tick();
    check_val("f0_v",  monitor_access_valid_out, 0);
    check_val("f0_hv", monitor_hit_vec_out, 0);
    access_dsid_in = 2'd1; tick();
    check_val("f1_v",  monitor_access_valid_out, 1);
    check_val("f1_hv", monitor_hit_vec_out, 16'h0004);
    access_dsid_in = 2'd0; tick();
    check_val("f2_v",  monitor_access_valid_out, 0);
    check_val("f2_hv", monitor_hit_vec_out, 0);
    access_dsid_in = 2'd1; tick();
    check_val("f3_v",  monitor_access_valid_out, 1);
    check_val("f3_hv", monitor_hit_vec_out, 16'h0004);
    tick();
    check_val("f_settle_v",  monitor_access_valid_out, 0);
    check_val("f_settle_hv", monitor_hit_vec_out, 0);
    access_valid_in = 1'b0; hit_vec_in = 16'h0;

    // Stalled commit with an all-zero suggestion
    cfg_ready_in = 1'b0; suggested_waymask_in = 16'h0000;
    wait_valid("st_to", 40, cyc);
    check_val("st_lat", cyc, 8);
    for (int i = 0; i < 10; i++) begin
      check_val("st_v", cfg_valid_out, 1);
      check_val("st_d", cfg_dsid_out, 1);
      check_val("st_m", cfg_waymask_out, 16'h0001);
      tick();
    end
    check_val("st_nohs", hs_log.size(), 1);
    cfg_ready_in = 1'b1;
    tick();
    check_val("st_drop",  cfg_valid_out, 0);
    check_val("st_cur",   cur_dsid_out, 2);
    check_val("st_pulse", monitor_reset_out, 1);
    check_val("st_onehs", hs_log.size(), 2);

    // 1-cycle epochs rotating through DSIDs 2, 3, 0
    epoch_len_in = 32'd0; suggested_waymask_in = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      wait_valid("rot_to", 40, cyc);
      check_val("rot_lat",  cyc, 10);
      check_val("rot_dsid", cfg_dsid_out, (k + 2) % 4);
      check_val("rot_mask", cfg_waymask_out, 16'h1234);
      tick();
    end
    check_val("rot_wrap", cur_dsid_out, 1);

    // enable dropped mid-epoch: epoch and commit still complete, then IDLE
    epoch_len_in = 32'd6;
    tick(); tick();
    enable_in = 1'b0;
    wait_valid("en_to", 60, cyc);
    check_val("en_lat",  cyc, 13);
    check_val("en_dsid", cfg_dsid_out, 1);
    tick();
    check_val("en_busy",  busy_out, 0);
    check_val("en_valid", cfg_valid_out, 0);
    check_val("en_cur",   cur_dsid_out, 2);
    check_val("en_pulse", monitor_reset_out, 0);
    repeat (5) tick();
    check_val("en_idle", busy_out, 0);

    check_val("hs_count", hs_log.size(), 6);
    begin
      logic [1:0] exp_seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
      for (int i = 0; i < 6 && i < hs_log.size(); i++)
        check_val("hs_seq", hs_log[i], exp_seq[i]);
    end

    // Reset while a commit is pending
    enable_in = 1'b1; cfg_ready_in = 1'b0; epoch_len_in = 32'd1;
    suggested_waymask_in = 16'h00F0;
    tick();
    wait_valid("rc_to", 40, cyc);
    check_val("rc_lat",  cyc, 10);
    check_val("rc_mask", cfg_waymask_out, 16'h00F0);
    check_val("rc_dsid", cfg_dsid_out, 2);
    reset_in = 1'b1;
    tick();
    check_val("rc_valid", cfg_valid_out, 0);
    check_val("rc_mask0", cfg_waymask_out, 16'hFFFF);
    check_val("rc_cur",   cur_dsid_out, 0);
    check_val("rc_busy",  busy_out, 0);
    check_val("rc_mrst",  monitor_reset_out, 1);
    reset_in = 1'b0; enable_in = 1'b0;
    tick();
    check_val("rc_nohs", hs_log.size(), 6);

`ifdef AUTOCAT_SCHED_SKIP_SAME_EN
    // Constant suggestion: first round commits, second round is skipped
    enable_in = 1'b1; cfg_ready_in = 1'b1; epoch_len_in = 32'd1;
    suggested_waymask_in = 16'h0F0F;
    tick();
    for (int d = 0; d < 4; d++) begin
      wait_valid("sk_to", 40, cyc);
      check_val("sk_dsid", cfg_dsid_out, d);
      tick();
    end
    begin
      int seen = 0;
      int changes = 0;
      logic [1:0] prev;
      prev = cur_dsid_out;
      for (int i = 0; i < 45; i++) begin
        tick();
        if (cfg_valid_out) seen++;
        if (cur_dsid_out != prev) begin
          changes++;
          prev = cur_dsid_out;
        end
      end
      check_val("sk_novalid", seen, 0);
      check_val("sk_rotate",  changes, 4);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/autocat_epoch_sched.md
Name: autocat_epoch_sched

Overview:
- Time-multiplexes one autocat way-partition monitor across NUM_DSID tenants (DSIDs) sharing a 16-way LLC.
- Each epoch profiles one DSID:
  - resets the monitor;
  - forwards only that DSID's access and hit-vector traffic;
  - waits for the sorter pipeline to settle;
  - samples the suggested waymask and commits it to the cache partition config through a valid/ready handshake.
- Sits between the LLC tag-lookup stage, the autocat monitor, and the LLC waymask control registers.

Parameters:
- NUM_DSID, 4, number of tenants scheduled round-robin (power of 2, ≥2).
- DSID_WIDTH, 2, log2(NUM_DSID).
- CACHE_ASSOCIATIVITY, 16, ways; width of hit vectors and waymasks.
- EPOCH_WIDTH, 32, width of the epoch-length counter.
- SETTLE_CYCLES, 8, cycles waited after an epoch before the suggestion is sampled (≥ sorter latency + 2).

Ports:
- clk_in  in  1  clock.
- reset_in  in  1  synchronous, active-high reset.
- enable_in  in  1  scheduler run enable.
- epoch_len_in  in  EPOCH_WIDTH  monitoring cycles per epoch; 0 treated as 1.
- access_valid_in  in  1  LLC lookup valid.
- access_dsid_in  in  DSID_WIDTH  DSID of the lookup.
- hit_vec_in  in  CACHE_ASSOCIATIVITY  per-way hit vector of the lookup.
- monitor_reset_out  out  1  one-cycle pulse that resets the monitor.
- monitor_access_valid_out  out  1  filtered access valid to the monitor.
- monitor_hit_vec_out  out  CACHE_ASSOCIATIVITY  filtered hit vector to the monitor.
- suggested_waymask_in  in  CACHE_ASSOCIATIVITY  monitor suggestion.
- cfg_valid_out  out  1  waymask commit request.
- cfg_dsid_out  out  DSID_WIDTH  target DSID of the commit.
- cfg_waymask_out  out  CACHE_ASSOCIATIVITY  waymask to commit.
- cfg_ready_in  in  1  config block accepts the commit.
- cur_dsid_out  out  DSID_WIDTH  DSID currently being profiled.
- busy_out  out  1  high in any state other than IDLE.

Behaviour:
- Reset values:
  - state IDLE;
  - cur_dsid 0;
  - epoch counter 0;
  - monitor_reset_out 1 during reset, otherwise 0;
  - monitor_access_valid_out 0;
  - monitor_hit_vec_out 0;
  - cfg_valid_out 0;
  - cfg_dsid_out 0;
  - cfg_waymask_out all ones;
  - busy_out 0.
- Filter: registered, 1-cycle latency.
  - monitor_access_valid_out <= access_valid_in & (access_dsid_in == cur_dsid) & (state == MONITOR).
  - monitor_hit_vec_out <= hit_vec_in when that condition holds, else 0.
- IDLE:
  - enable_in=1 → pulse monitor_reset_out for 1 cycle, clear epoch counter, go to MONITOR.
- MONITOR:
  - epoch counter increments every cycle.
  - When counter == max(epoch_len_in,1)-1 → go to SETTLE and clear the counter.
  - epoch_len_in is sampled live; a change mid-epoch takes effect immediately. If the counter is already beyond the new value, the epoch ends at the counter's wrap to 0 and the following match.
- SETTLE:
  - Filter outputs are forced 0.
  - Count SETTLE_CYCLES cycles, then register cfg_waymask_out <= suggested_waymask_in.
  - An all-zero suggestion is replaced by {{(CA-1){0}},1} (way 0 only; a DSID is never starved).
  - cfg_dsid_out <= cur_dsid; go to COMMIT.
- COMMIT:
  - cfg_valid_out=1. cfg_dsid_out and cfg_waymask_out stay stable until the handshake.
  - Transfer occurs on the cycle cfg_valid_out & cfg_ready_in. On that cycle:
    - cur_dsid <= cur_dsid+1 (wraps NUM_DSID-1 → 0);
    - cfg_valid_out drops the next cycle.
  - After transfer: if enable_in=1, pulse monitor_reset_out and go to MONITOR; else go to IDLE.
- enable_in deassertion outside COMMIT is ignored until the current epoch's commit completes. No partial epochs are discarded except by reset.
- cfg_ready_in high outside COMMIT has no effect.
- reset_in mid-operation: all state returns to reset values next cycle; any pending commit is dropped.
- busy_out = (state != IDLE).

Optional Feature:
- Macro AUTOCAT_SCHED_SKIP_SAME_EN.
- Defined:
  - A per-DSID shadow table, reset to all ones, holds the last committed waymask.
  - In SETTLE, if the filtered suggestion equals the shadow entry, skip COMMIT: advance cur_dsid and go directly to MONITOR (pulse monitor_reset_out) or IDLE.
  - The shadow entry is written on each completed handshake.
- Undefined: every epoch produces a COMMIT handshake.

Test Plan:
- Reset, enable_in=1, epoch_len_in=4, suggestion 16'h00FF, cfg_ready_in=1 → monitor_reset_out pulse. SETTLE starts 4 cycles after MONITOR entry; cfg_valid_out rises SETTLE_CYCLES+1 cycles later with cfg_dsid_out=0, cfg_waymask_out=16'h00FF; cur_dsid_out becomes 1.
- Accesses alternating DSID 0/1 with hit_vec 16'h0004 while profiling DSID 1 → only DSID-1 accesses appear on monitor_access_valid_out, 1 cycle later; DSID-0 accesses give valid 0 and hit_vec 0.
- cfg_ready_in held 0 for 10 cycles in COMMIT, then 1 → cfg_valid_out, cfg_dsid_out and cfg_waymask_out stable all 10 cycles; exactly one transfer; next MONITOR begins after.
- suggestion 16'h0000 → cfg_waymask_out=16'h0001. Four full epochs → cfg_dsid_out sequence 0,1,2,3, then wraps to 0. epoch_len_in=0 → 1-cycle epochs.
- enable_in dropped mid-MONITOR → epoch completes, commit occurs, then IDLE with busy_out=0. reset_in asserted in COMMIT → cfg_valid_out=0 and cfg_waymask_out=16'hFFFF next cycle.
- With AUTOCAT_SCHED_SKIP_SAME_EN and a constant suggestion 16'h0F0F → first epoch per DSID commits; the second round produces no cfg_valid_out while cur_dsid_out still rotates.
